// File: rtl/sorcerer_cass_encoder.sv
// ---------------------------------------------------------------------------
// sorcerer_cass_encoder
//   Cassette write-side FSK encoder. Turns the UART serial output into a
//   phase-continuous square wave whose half-periods match the read decoder's
//   thresholds, so CASS_OUT looped back into CASS_IN reproduces the bit stream.
//
// Ports
//   CLK12      in   12 MHz system clock
//   RESET      in   synchronous, active-high reset
//   CEN_38400  in   one-cycle tick enable (38.4 kHz nominal)
//   ENABLE     in   run enable (motor control); 0 forces IDLE every cycle
//   BAUD_SEL   in   0 = 300 baud, 1 = 1200 baud (sampled at cell start)
//   TX_BIT     in   UART serial output, idle high
//   CASS_OUT   out  FSK square wave
//   CUR_BIT    out  bit value encoded in the current cell
//   BIT_CELL   out  one-cycle pulse following each cell start
// ---------------------------------------------------------------------------
module sorcerer_cass_encoder (
    input  logic CLK12,
    input  logic RESET,
    input  logic CEN_38400,
    input  logic ENABLE,
    input  logic BAUD_SEL,
    input  logic TX_BIT,
    output logic CASS_OUT,
    output logic CUR_BIT,
    output logic BIT_CELL
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t     r_state, w_state_nxt;
    logic       r_tx_d;
    logic       r_baud, w_baud_nxt;
    logic [6:0] r_cell_cnt, w_cell_cnt_nxt;
    logic [4:0] r_half_cnt, w_half_cnt_nxt;
    logic       r_cass, w_cass_nxt;
    logic       r_cur, w_cur_nxt;
    logic       r_pulse, w_pulse_nxt;
    logic [6:0] w_cell_last;
    logic [4:0] w_half_last;
    logic       w_cell_start;

    // TX_BIT capture stage; a sampling register only, so it carries no reset.
    always_ff @(posedge CLK12) begin
        r_tx_d <= TX_BIT;
    end

    // Terminal counts come from the baud latched at cell start, never from
    // the live BAUD_SEL, so a mid-cell baud change waits for the next cell.
    always_comb begin
        w_cell_last = r_baud ? 7'd31 : 7'd127;
        unique case ({r_baud, r_cur})
            2'b01:   w_half_last = 5'd7;   // 300 baud mark, 2400 Hz
            2'b00:   w_half_last = 5'd15;  // 300 baud space, 1200 Hz
            2'b11:   w_half_last = 5'd15;  // 1200 baud mark, 1200 Hz
            default: w_half_last = 5'd31;  // 1200 baud space, 600 Hz
        endcase
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_baud_nxt     = r_baud;
        w_cell_cnt_nxt = r_cell_cnt;
        w_half_cnt_nxt = r_half_cnt;
        w_cass_nxt     = r_cass;
        w_cur_nxt      = r_cur;
        w_pulse_nxt    = 1'b0;
        w_cell_start   = 1'b0;

        if (!ENABLE) begin
            w_state_nxt    = S_IDLE;
            w_cell_cnt_nxt = 7'd0;
            w_half_cnt_nxt = 5'd0;
            w_cass_nxt     = 1'b0;
            w_cur_nxt      = 1'b1;
        end else if (CEN_38400) begin
            // IDLE with ENABLE high means no tick has been seen since enable,
            // so the first tick always opens a cell.
            w_cell_start = (r_state == S_IDLE) ||
                           (r_cell_cnt == w_cell_last) ||
                           (r_tx_d != r_cur);
            w_state_nxt  = S_RUN;
            if (w_cell_start) begin
                w_cell_cnt_nxt = 7'd0;
                w_half_cnt_nxt = 5'd0;
                w_cur_nxt      = r_tx_d;
                w_baud_nxt     = BAUD_SEL;
                w_cass_nxt     = ~r_cass;
                w_pulse_nxt    = 1'b1;
            end else begin
                w_cell_cnt_nxt = r_cell_cnt + 7'd1;
                // A half-period ending on the cell boundary is absorbed by
                // the cell-start toggle above, keeping the tone continuous.
                if (r_half_cnt == w_half_last) begin
                    w_half_cnt_nxt = 5'd0;
                    w_cass_nxt     = ~r_cass;
                end else begin
                    w_half_cnt_nxt = r_half_cnt + 5'd1;
                end
            end
        end
    end

    always_ff @(posedge CLK12) begin
        if (RESET) begin
            r_state    <= S_IDLE;
            r_baud     <= 1'b0;
            r_cell_cnt <= 7'd0;
            r_half_cnt <= 5'd0;
            r_cass     <= 1'b0;
            r_cur      <= 1'b1;
            r_pulse    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_baud     <= w_baud_nxt;
            r_cell_cnt <= w_cell_cnt_nxt;
            r_half_cnt <= w_half_cnt_nxt;
            r_cass     <= w_cass_nxt;
            r_cur      <= w_cur_nxt;
            r_pulse    <= w_pulse_nxt;
        end
    end

    assign CASS_OUT = r_cass;
    assign CUR_BIT  = r_cur;
    assign BIT_CELL = r_pulse;

endmodule

// File: tb/tb_sorcerer_cass_encoder.sv
module tb_sorcerer_cass_encoder;

    logic CLK12 = 1'b0;
    logic RESET, CEN, ENABLE, BAUD_SEL, TX_BIT;
    logic CASS_OUT, CUR_BIT, BIT_CELL;

    int n_chk = 0;
    int n_pass = 0;

    // reference model state, advanced once per CLK12 edge
    logic m_out, m_cur, m_bc, m_run, m_baud, m_txd;
    int   m_age;

    always #5 CLK12 = ~CLK12;

    sorcerer_cass_encoder dut (
        .CLK12(CLK12), .RESET(RESET), .CEN_38400(CEN), .ENABLE(ENABLE),
        .BAUD_SEL(BAUD_SEL), .TX_BIT(TX_BIT),
        .CASS_OUT(CASS_OUT), .CUR_BIT(CUR_BIT), .BIT_CELL(BIT_CELL)
    );

    function automatic int cell_len(input logic b);
        return b ? 32 : 128;
    endfunction

    function automatic int half_len(input logic b, input logic c);
        if (!b) return c ? 8 : 16;
        return c ? 16 : 32;
    endfunction

    // Behaviour in terms of "ticks since cell start": a toggle happens at
    // the cell start and whenever that age is a multiple of the half-period.
    task automatic model_edge();
        logic start;
        if (RESET || !ENABLE) begin
            m_out = 0; m_cur = 1; m_bc = 0; m_run = 0; m_age = 0;
        end else if (CEN) begin
            start = !m_run || (m_age + 1 == cell_len(m_baud)) || (m_txd != m_cur);
            if (start) begin
                m_age = 0; m_cur = m_txd; m_baud = BAUD_SEL;
                m_out = ~m_out; m_bc = 1; m_run = 1;
            end else begin
                m_age++;
                if (m_age % half_len(m_baud, m_cur) == 0) m_out = ~m_out;
                m_bc = 0;
            end
        end else begin
            m_bc = 0;
        end
        m_txd = TX_BIT;
    endtask

    task automatic clk_step(input logic tick);
        CEN = tick;
        @(posedge CLK12);
        model_edge();
        #1;
    endtask

    task automatic advance_tick();
        repeat ($urandom_range(0, 3)) clk_step(0);
        clk_step(1);
    endtask

    task automatic test_reset();
        RESET = 1; ENABLE = 1; TX_BIT = 1; BAUD_SEL = 0;
        repeat (3) clk_step(1);
        n_chk++; if (CASS_OUT !== 1'b0) $display("FAIL reset_out got %b want 0", CASS_OUT); else n_pass++;
        n_chk++; if (CUR_BIT !== 1'b1) $display("FAIL reset_cur got %b want 1", CUR_BIT); else n_pass++;
        n_chk++; if (BIT_CELL !== 1'b0) $display("FAIL reset_bitcell got %b want 0", BIT_CELL); else n_pass++;
    endtask

    task automatic test_tone_300_one();
        int tg, bc, errs, last_t;
        logic prev;
        RESET = 0; ENABLE = 0; BAUD_SEL = 0; TX_BIT = 1; clk_step(0);
        ENABLE = 1; clk_step(0); clk_step(0);
        clk_step(1);
        n_chk++; if (CASS_OUT !== 1'b1) $display("FAIL first_tick_out got %b want 1", CASS_OUT); else n_pass++;
        n_chk++; if (BIT_CELL !== 1'b1) $display("FAIL first_tick_bitcell got %b want 1", BIT_CELL); else n_pass++;
        clk_step(0);
        n_chk++; if (BIT_CELL !== 1'b0) $display("FAIL bitcell_width got %b want 0", BIT_CELL); else n_pass++;
        prev = CASS_OUT; tg = 0; bc = 0; errs = 0; last_t = 0;
        for (int t = 1; t <= 128; t++) begin
            advance_tick();
            if (CASS_OUT !== prev) begin
                tg++; if (t - last_t != 8) errs++;
                last_t = t; prev = CASS_OUT;
            end
            if (BIT_CELL === 1'b1) bc++;
        end
        n_chk++; if (tg != 16) $display("FAIL t300_one_toggles got %0d want 16", tg); else n_pass++;
        n_chk++; if (errs != 0) $display("FAIL t300_one_spacing bad_gaps %0d want 0", errs); else n_pass++;
        n_chk++; if (bc != 1) $display("FAIL t300_one_cells got %0d want 1", bc); else n_pass++;
        n_chk++; if (CUR_BIT !== 1'b1) $display("FAIL t300_one_cur got %b want 1", CUR_BIT); else n_pass++;
    endtask

    task automatic test_tone_300_zero();
        int tg, errs, last_t, n;
        logic prev;
        ENABLE = 0; BAUD_SEL = 0; TX_BIT = 0; clk_step(0);
        ENABLE = 1; clk_step(0);
        advance_tick();
        n_chk++; if (CUR_BIT !== 1'b0) $display("FAIL t300_zero_cur got %b want 0", CUR_BIT); else n_pass++;
        prev = CASS_OUT; tg = 0; errs = 0; last_t = 0;
        for (int t = 1; t <= 128; t++) begin
            advance_tick();
            if (CASS_OUT !== prev) begin
                tg++; if (t - last_t != 16) errs++;
                last_t = t; prev = CASS_OUT;
            end
        end
        n_chk++; if (tg != 8) $display("FAIL t300_zero_toggles got %0d want 8", tg); else n_pass++;
        n_chk++; if (errs != 0) $display("FAIL t300_zero_spacing bad_gaps %0d want 0", errs); else n_pass++;
        repeat (50) advance_tick();
        TX_BIT = 1; clk_step(0); clk_step(1);
        n_chk++; if (BIT_CELL !== 1'b1) $display("FAIL resync_bitcell got %b want 1", BIT_CELL); else n_pass++;
        n_chk++; if (CUR_BIT !== 1'b1) $display("FAIL resync_cur got %b want 1", CUR_BIT); else n_pass++;
        n_chk++; if (CASS_OUT !== m_out) $display("FAIL resync_out got %b want %b", CASS_OUT, m_out); else n_pass++;
        prev = CASS_OUT; n = -1;
        for (int t = 1; t <= 40; t++) begin
            advance_tick();
            if (CASS_OUT !== prev) begin n = t; break; end
        end
        n_chk++; if (n != 8) $display("FAIL resync_next_toggle got %0d ticks want 8", n); else n_pass++;
    endtask

    task automatic test_byte_1200();
        logic [10:0] frame, got_seq;
        int cells, errs;
        logic prev, want_tg;
        frame = {1'b1, 1'b1, 8'h55, 1'b0};
        got_seq = '0; cells = 0; errs = 0;
        ENABLE = 0; BAUD_SEL = 1; TX_BIT = 1; clk_step(0);
        ENABLE = 1;
        repeat (40) advance_tick();
        for (int i = 0; i < 11; i++) begin
            TX_BIT = frame[i]; clk_step(0);
            for (int t = 0; t < 32; t++) begin
                prev = CASS_OUT;
                advance_tick();
                if (t == 0) begin
                    got_seq[i] = CUR_BIT;
                    if (BIT_CELL === 1'b1) cells++;
                end
                want_tg = (t == 0) || (frame[i] && t == 16);
                if ((CASS_OUT !== prev) != want_tg) errs++;
            end
        end
        n_chk++; if (got_seq !== frame) $display("FAIL byte_cur_seq got %b want %b", got_seq, frame); else n_pass++;
        n_chk++; if (cells != 11) $display("FAIL byte_cells got %0d want 11", cells); else n_pass++;
        n_chk++; if (errs != 0) $display("FAIL byte_toggle_pos bad_ticks %0d want 0", errs); else n_pass++;
    endtask

    task automatic test_baud_switch();
        int tg, len;
        logic prev;
        ENABLE = 0; BAUD_SEL = 0; TX_BIT = 1; clk_step(0);
        ENABLE = 1; advance_tick();
        prev = CASS_OUT; tg = 0; len = -1;
        for (int t = 1; t <= 300; t++) begin
            if (t == 41) BAUD_SEL = 1;
            advance_tick();
            if (CASS_OUT !== prev) begin tg++; prev = CASS_OUT; end
            if (BIT_CELL === 1'b1) begin len = t; break; end
        end
        n_chk++; if (len != 128) $display("FAIL baud_sw_len1 got %0d want 128", len); else n_pass++;
        n_chk++; if (tg != 16) $display("FAIL baud_sw_tg1 got %0d want 16", tg); else n_pass++;
        tg = 0; len = -1;
        for (int t = 1; t <= 300; t++) begin
            advance_tick();
            if (CASS_OUT !== prev) begin tg++; prev = CASS_OUT; end
            if (BIT_CELL === 1'b1) begin len = t; break; end
        end
        n_chk++; if (len != 32) $display("FAIL baud_sw_len2 got %0d want 32", len); else n_pass++;
        n_chk++; if (tg != 2) $display("FAIL baud_sw_tg2 got %0d want 2", tg); else n_pass++;
    endtask

    // use_reset=0 drops ENABLE mid-cell, use_reset=1 pulses RESET instead
    task automatic test_abort(input bit use_reset);
        int n;
        logic prev;
        string nm;
        nm = use_reset ? "rst" : "en";
        ENABLE = 0; BAUD_SEL = 0; TX_BIT = 0; clk_step(0);
        ENABLE = 1; advance_tick();
        repeat (50) advance_tick();
        if (use_reset) RESET = 1; else ENABLE = 0;
        clk_step(1);
        n_chk++; if (CASS_OUT !== 1'b0) $display("FAIL %s_abort_out got %b want 0", nm, CASS_OUT); else n_pass++;
        n_chk++; if (CUR_BIT !== 1'b1) $display("FAIL %s_abort_cur got %b want 1", nm, CUR_BIT); else n_pass++;
        n_chk++; if (BIT_CELL !== 1'b0) $display("FAIL %s_abort_bitcell got %b want 0", nm, BIT_CELL); else n_pass++;
        RESET = 0; ENABLE = 1; clk_step(0);
        n_chk++; if (CASS_OUT !== 1'b0) $display("FAIL %s_no_tick_out got %b want 0", nm, CASS_OUT); else n_pass++;
        clk_step(1);
        n_chk++; if (CASS_OUT !== 1'b1) $display("FAIL %s_reen_out got %b want 1", nm, CASS_OUT); else n_pass++;
        n_chk++; if (BIT_CELL !== 1'b1) $display("FAIL %s_reen_bitcell got %b want 1", nm, BIT_CELL); else n_pass++;
        prev = CASS_OUT; n = -1;
        for (int t = 1; t <= 40; t++) begin
            advance_tick();
            if (CASS_OUT !== prev) begin n = t; break; end
        end
        n_chk++; if (n != 16) $display("FAIL %s_reen_next_toggle got %0d ticks want 16", nm, n); else n_pass++;
    endtask

    task automatic test_random();
        int e_out, e_cur, e_bc, first;
        e_out = 0; e_cur = 0; e_bc = 0; first = -1;
        ENABLE = 1; RESET = 0;
        for (int c = 0; c < 8000; c++) begin
            RESET = ($urandom_range(0, 1999) == 0);
            if ($urandom_range(0, 599) == 0) ENABLE = ~ENABLE;
            if (!ENABLE && $urandom_range(0, 19) == 0) ENABLE = 1;
            if ($urandom_range(0, 399) == 0) TX_BIT = ~TX_BIT;
            if ($urandom_range(0, 299) == 0) BAUD_SEL = ~BAUD_SEL;
            clk_step($urandom_range(0, 2) == 0);
            if (CASS_OUT !== m_out) e_out++;
            if (CUR_BIT !== m_cur) e_cur++;
            if (BIT_CELL !== m_bc) e_bc++;
            if (first < 0 && (e_out + e_cur + e_bc) != 0) first = c;
        end
        n_chk++; if (e_out != 0) $display("FAIL rand_out bad_cycles %0d want 0 (first at %0d)", e_out, first); else n_pass++;
        n_chk++; if (e_cur != 0) $display("FAIL rand_cur bad_cycles %0d want 0 (first at %0d)", e_cur, first); else n_pass++;
        n_chk++; if (e_bc != 0) $display("FAIL rand_bitcell bad_cycles %0d want 0 (first at %0d)", e_bc, first); else n_pass++;
    endtask

    initial begin
        RESET = 1; ENABLE = 0; BAUD_SEL = 0; TX_BIT = 1; CEN = 0;
        m_out = 0; m_cur = 1; m_bc = 0; m_run = 0; m_baud = 0; m_txd = 1; m_age = 0;
        test_reset();
        test_tone_300_one();
        test_tone_300_zero();
        test_byte_1200();
        test_baud_switch();
        test_abort(0);
        test_abort(1);
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sorcerer_cass_encoder.md
# sorcerer_cass_encoder

Cassette write-side FSK encoder for the Sorcerer core, the transmit counterpart of the cassette read decoder. It converts the UART serial output (TX_BIT, idle high) into a square-wave tone on CASS_OUT. Tone timing comes from the shared 38.4 kHz-nominal clock enable, and the tone half-periods match the thresholds of the read decoder, so a loopback from CASS_OUT to CASS_IN returns the same bit stream. It sits beside the UART and is driven by the cassette-control port bits.

## Interface
Parameters:
- none. Timing is fixed by the CEN_38400 rate.

Ports:
- CLK12  in  1  system clock, 12 MHz
- RESET  in  1  synchronous, active-high
- CEN_38400  in  1  one-CLK12-cycle tick enable ("tick" below)
- ENABLE  in  1  encoder run enable (motor_ctrl bit); 0 forces IDLE
- BAUD_SEL  in  1  0 = 300 baud, 1 = 1200 baud
- TX_BIT  in  1  UART serial output, CLK12 domain
- CASS_OUT  out  1  FSK square wave
- CUR_BIT  out  1  bit value being encoded in the current cell
- BIT_CELL  out  1  one-CLK12 pulse at each cell start

## Operation
- tx_d is TX_BIT registered once.
- States:
  - IDLE: entered on RESET or ENABLE=0. CASS_OUT=0, CUR_BIT=1, cell_cnt=0, half_cnt=0, BIT_CELL=0.
  - RUN: entered when ENABLE=1.
- Every CLK12 cycle with ENABLE=0 forces IDLE synchronously, including mid-cell.
- Timing lengths in ticks:
  - Cell length, latched at cell start: 128 ticks at 300 baud, 32 ticks at 1200 baud.
  - Half-period, selected by cur_bit and latched baud:
    - 300 baud: bit 1 = 8 ticks (2400 Hz), bit 0 = 16 ticks (1200 Hz).
    - 1200 baud: bit 1 = 16 ticks (1200 Hz), bit 0 = 32 ticks (600 Hz).
- Cell start occurs on a tick in RUN when any of these holds:
  - first tick after entering RUN; or
  - cell_cnt == cell_len-1; or
  - tx_d != CUR_BIT (edge resync).
- At a cell start:
  - cell_cnt←0, half_cnt←0;
  - CUR_BIT←tx_d;
  - baud latched from BAUD_SEL;
  - CASS_OUT toggles;
  - BIT_CELL pulses.
- Other RUN ticks:
  - cell_cnt++, half_cnt++.
  - If half_cnt == half_len-1: half_cnt←0 and CASS_OUT toggles.
- The cell length is an integer multiple of every half-period, so a half-period end coinciding with the cell end yields exactly one toggle, the cell-start toggle. The tone is phase-continuous.
- Toggles per full cell: 300 baud, bit 1 = 16 and bit 0 = 8; 1200 baud, bit 1 = 2 and bit 0 = 1.
- Edge resync: the first UART edge aligns the cells. After that, UART edges fall on cell boundaries because the UART bit period equals cell_len.
- Non-tick cycles change nothing except the tx_d register and the BIT_CELL clear.
- Width rules:
  - cell_cnt is 7 bits and never exceeds 127.
  - half_cnt is 5 bits and never exceeds 31.
  - No arithmetic wrap is relied on.

## Timing
- Reset values: CASS_OUT=0, CUR_BIT=1, BIT_CELL=0, state IDLE.
- Output latency:
  - CASS_OUT, CUR_BIT and BIT_CELL update on the CLK12 edge after the qualifying tick cycle.
  - BIT_CELL is high for exactly one CLK12 cycle.
- TX_BIT to resync latency: one register stage (tx_d), then the next tick.
- BAUD_SEL changes mid-cell have no effect until the next cell start.
- ENABLE 0→1: the first tick starts a cell, so CASS_OUT goes 0→1.
- ENABLE 1→0: CASS_OUT=0 on the next CLK12 edge.
- Simultaneous events on one tick:
  - Cell end plus edge resync: one cell start, one toggle.
  - ENABLE=0 or RESET overrides everything.
- Reset mid-cell: full IDLE state next cycle. No partial toggle is emitted.

## Test plan
- 300 baud, TX_BIT=1, ENABLE=1, ticks every 312 CLK12 -> first toggle on tick 0, then CASS_OUT toggles every 8 ticks; 16 toggles and one BIT_CELL per 128 ticks.
- 300 baud, TX_BIT held 0 -> toggles every 16 ticks (8 per cell); CUR_BIT=0. Switch TX_BIT to 1 mid-cell -> new cell and toggle on the next tick, then 8-tick spacing.
- 1200 baud, byte 0x55 framed 8N1 by the UART model -> CUR_BIT sequence 0,1,0,1,0,1,0,1,0,1,1 across 32-tick cells. One toggle in each 0-cell; toggles at 0 and 16 in each 1-cell.
- BAUD_SEL 0→1 at cell_cnt=40 -> remaining cell keeps 128-tick length and 300-baud half-periods; the next cell is 32 ticks.
- ENABLE dropped at cell_cnt=50, and separately RESET pulsed mid-cell -> CASS_OUT=0, CUR_BIT=1 and counters 0 the next cycle. Re-enable -> toggle to 1 on the first tick.
- Loopback of CASS_OUT into the read decoder at both bauds with 256 random bytes -> UART receive data matches with no framing or overrun errors.
